// File: rtl/reg_universal.sv
// Universal register: load, shifts, rotates, increment and a multi-cycle shift-by-N.
// Optional synchronous preset (PR port) is built when REG_SYNC_PRESET_EN is defined.
module reg_universal #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             CLR,
    input  logic [2:0]       mode,
    input  logic             en,
    input  logic [WIDTH-1:0] D,
    input  logic             sin,
    input  logic [AMT_W-1:0] amt,
    input  logic             dir,
`ifdef REG_SYNC_PRESET_EN
    input  logic             PR,
`endif
    output logic [WIDTH-1:0] Q,
    output logic             cout,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_LOAD = 3'd1;
    localparam logic [2:0] MODE_SHL  = 3'd2;
    localparam logic [2:0] MODE_SHR  = 3'd3;
    localparam logic [2:0] MODE_ROL  = 3'd4;
    localparam logic [2:0] MODE_ROR  = 3'd5;
    localparam logic [2:0] MODE_INC  = 3'd6;
    localparam logic [2:0] MODE_SHN  = 3'd7;

    logic [0:0]       state, state_nxt;
    logic [AMT_W-1:0] cnt, cnt_nxt;
    logic             dir_q, dir_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             cout_nxt;
    logic             done_nxt;

    assign busy = (state == SHIFT);

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        q_nxt     = Q;
        cout_nxt  = cout;
        state_nxt = state;
        cnt_nxt   = cnt;
        dir_nxt   = dir_q;
        done_nxt  = 1'b0;
        if (state == SHIFT) begin
            if (dir_q) begin
                q_nxt    = {1'b0, Q[WIDTH-1:1]};
                cout_nxt = Q[0];
            end else begin
                q_nxt    = {Q[WIDTH-2:0], 1'b0};
                cout_nxt = Q[WIDTH-1];
            end
            cnt_nxt = cnt - 1'b1;
            if (cnt == AMT_W'(1)) begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end
        end else if (en) begin
            case (mode)
                MODE_HOLD: ;
                MODE_LOAD: begin
                    q_nxt    = D;
                    cout_nxt = 1'b0;
                end
                MODE_SHL: begin
                    q_nxt    = {Q[WIDTH-2:0], sin};
                    cout_nxt = Q[WIDTH-1];
                end
                MODE_SHR: begin
                    q_nxt    = {sin, Q[WIDTH-1:1]};
                    cout_nxt = Q[0];
                end
                MODE_ROL: begin
                    q_nxt    = {Q[WIDTH-2:0], Q[WIDTH-1]};
                    cout_nxt = Q[WIDTH-1];
                end
                MODE_ROR: begin
                    q_nxt    = {Q[0], Q[WIDTH-1:1]};
                    cout_nxt = Q[0];
                end
                MODE_INC: {cout_nxt, q_nxt} = {1'b0, Q} + (WIDTH+1)'(1);
                MODE_SHN: begin
                    dir_nxt = dir;
                    cnt_nxt = amt;
                    // A zero count completes on the sampling edge without entering SHIFT.
                    if (amt == '0) done_nxt  = 1'b1;
                    else           state_nxt = SHIFT;
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the register updates on the falling edge.
    always_ff @(negedge clk or negedge CLR) begin
        if (!CLR) begin
            Q     <= '0;
            cout  <= 1'b0;
            zero  <= 1'b1;
            done  <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
            dir_q <= 1'b0;
`ifdef REG_SYNC_PRESET_EN
        end else if (PR) begin
            Q     <= '1;
            cout  <= 1'b0;
            zero  <= 1'b0;
            done  <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
`endif
        end else begin
            Q     <= q_nxt;
            cout  <= cout_nxt;
            zero  <= (q_nxt == '0);
            done  <= done_nxt;
            state <= state_nxt;
            cnt   <= cnt_nxt;
            dir_q <= dir_nxt;
        end
    end

endmodule

// File: tb/tb_reg_universal.sv
// Directed bench for reg_universal: table of single-cycle ops plus SHN, reset-abort and preset sequences.
module tb_reg_universal;
    localparam int WIDTH = 8;
    localparam int AMT_W = 3;

    localparam logic [2:0] M_HOLD = 3'd0, M_LOAD = 3'd1, M_SHL = 3'd2, M_SHR = 3'd3;
    localparam logic [2:0] M_ROL  = 3'd4, M_ROR  = 3'd5, M_INC = 3'd6, M_SHN = 3'd7;

    logic             clk = 1'b0;
    logic             CLR = 1'b0;
    logic [2:0]       mode = '0;
    logic             en = 1'b0;
    logic [WIDTH-1:0] D = '0;
    logic             sin = 1'b0;
    logic [AMT_W-1:0] amt = '0;
    logic             dir = 1'b0;
`ifdef REG_SYNC_PRESET_EN
    logic             PR = 1'b0;
`endif
    logic [WIDTH-1:0] Q;
    logic             cout, zero, busy, done;

    int checks = 0;
    int failures = 0;

    reg_universal #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk  (clk),
        .CLR  (CLR),
        .mode (mode),
        .en   (en),
        .D    (D),
        .sin  (sin),
        .amt  (amt),
        .dir  (dir),
`ifdef REG_SYNC_PRESET_EN
        .PR   (PR),
`endif
        .Q    (Q),
        .cout (cout),
        .zero (zero),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] eq, input logic ec, input logic ez,
                             input logic eb, input logic ed);
        check({tag, ".Q"},    32'(Q),    32'(eq));
        check({tag, ".cout"}, 32'(cout), 32'(ec));
        check({tag, ".zero"}, 32'(zero), 32'(ez));
        check({tag, ".busy"}, 32'(busy), 32'(eb));
        check({tag, ".done"}, 32'(done), 32'(ed));
    endtask

    // Drive inputs mid-cycle, then let one falling edge happen and sample 1 ns later.
    task automatic cyc(input logic [2:0] m, input logic e, input logic [7:0] d, input logic s,
                       input logic [2:0] a, input logic dr);
        mode = m; en = e; D = d; sin = s; amt = a; dir = dr;
        @(negedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0] mode;
        logic       en;
        logic [7:0] d;
        logic       sin;
        logic [7:0] q;
        logic       c;
        logic       z;
    } vec_t;

    vec_t vecs[13];
    int   done_cnt;
    int   busy_cnt;

    initial begin
        vecs[0]  = '{M_LOAD, 1'b1, 8'hA5, 1'b0, 8'hA5, 1'b0, 1'b0};
        vecs[1]  = '{M_LOAD, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0}; // en low holds
        vecs[2]  = '{M_HOLD, 1'b1, 8'h3C, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[3]  = '{M_LOAD, 1'b1, 8'h81, 1'b0, 8'h81, 1'b0, 1'b0};
        vecs[4]  = '{M_ROL,  1'b1, 8'h00, 1'b0, 8'h03, 1'b1, 1'b0};
        vecs[5]  = '{M_SHR,  1'b1, 8'h00, 1'b1, 8'h81, 1'b1, 1'b0};
        vecs[6]  = '{M_SHL,  1'b1, 8'h00, 1'b0, 8'h02, 1'b1, 1'b0};
        vecs[7]  = '{M_ROR,  1'b1, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[8]  = '{M_SHR,  1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[9]  = '{M_LOAD, 1'b1, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[10] = '{M_INC,  1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[11] = '{M_INC,  1'b1, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[12] = '{M_SHL,  1'b1, 8'h00, 1'b1, 8'h03, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_all("reset", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        CLR = 1'b1;

        for (int i = 0; i < 13; i++) begin
            cyc(vecs[i].mode, vecs[i].en, vecs[i].d, vecs[i].sin, 3'd0, 1'b0);
            check_all($sformatf("vec%0d", i), vecs[i].q, vecs[i].c, vecs[i].z, 1'b0, 1'b0);
        end

        // SHN left by 5 from 01, with a LOAD issued while busy
        cyc(M_LOAD, 1'b1, 8'h01, 1'b0, 3'd0, 1'b0);
        cyc(M_SHN, 1'b1, 8'h00, 1'b0, 3'd5, 1'b0);
        check_all("shn5.start", 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
        busy_cnt = 1;
        done_cnt = 0;
        for (int k = 1; k <= 5; k++) begin
            cyc(M_LOAD, 1'b1, 8'hAA, 1'b1, 3'd2, 1'b1);
            check($sformatf("shn5.q%0d", k), 32'(Q), 32'(8'h01 << k));
            check($sformatf("shn5.busy%0d", k), 32'(busy), 32'(k < 5));
            if (busy) busy_cnt++;
            if (done) done_cnt++;
        end
        check("shn5.cout", 32'(cout), 32'(1'b0));
        check("shn5.busy_cycles", 32'(busy_cnt), 32'd5);
        check("shn5.done_pulses", 32'(done_cnt), 32'd1);
        check("shn5.done_last", 32'(done), 32'd1);
        // New op is accepted during the done cycle
        cyc(M_LOAD, 1'b1, 8'h3C, 1'b0, 3'd0, 1'b0);
        check_all("after_done", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);

        // SHN right by 3 from 0B: 05(c1) 02(c1) 01(c0)
        cyc(M_LOAD, 1'b1, 8'h0B, 1'b0, 3'd0, 1'b0);
        cyc(M_SHN, 1'b1, 8'h00, 1'b0, 3'd3, 1'b1);
        done_cnt = 0;
        for (int k = 1; k <= 3; k++) begin
            cyc(M_HOLD, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
            if (done) done_cnt++;
        end
        check_all("shr3", 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
        check("shr3.done_pulses", 32'(done_cnt), 32'd1);

        // SHN with amt = 0 completes at once
        cyc(M_SHN, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0);
        check_all("shn0", 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(M_HOLD, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        check_all("shn0.after", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset during the third cycle of an amt = 7 SHN
        cyc(M_LOAD, 1'b1, 8'h01, 1'b0, 3'd0, 1'b0);
        cyc(M_SHN, 1'b1, 8'h00, 1'b0, 3'd7, 1'b0);
        cyc(M_HOLD, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        cyc(M_HOLD, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        check_all("clr.pre", 8'h04, 1'b0, 1'b0, 1'b1, 1'b0);
        #2;
        CLR = 1'b0;
        #1;
        check_all("clr.async", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        @(posedge clk);
        CLR = 1'b1;
        done_cnt = 0;
        busy_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            cyc(M_HOLD, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
            if (done) done_cnt++;
            if (busy) busy_cnt++;
        end
        check("clr.no_done", 32'(done_cnt), 32'd0);
        check("clr.no_busy", 32'(busy_cnt), 32'd0);
        cyc(M_LOAD, 1'b1, 8'h77, 1'b0, 3'd0, 1'b0);
        check_all("clr.first_op", 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef REG_SYNC_PRESET_EN
        // Preset aborts a running SHN without a done pulse
        cyc(M_LOAD, 1'b1, 8'h01, 1'b0, 3'd0, 1'b0);
        cyc(M_SHN, 1'b1, 8'h00, 1'b0, 3'd7, 1'b0);
        cyc(M_HOLD, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        PR = 1'b1;
        cyc(M_LOAD, 1'b1, 8'h12, 1'b0, 3'd0, 1'b0);
        PR = 1'b0;
        check_all("preset", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        done_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            cyc(M_HOLD, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
            if (done) done_cnt++;
        end
        check("preset.no_done", 32'(done_cnt), 32'd0);
        check("preset.hold", 32'(Q), 32'(8'hFF));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
